// File: rtl/matrix_input_loader.sv
// -----------------------------------------------------------------------------
// matrix_input_loader
//
// Collects two NOF_ROWS x NOF_COLS matrices (A, then B) from a single
// valid/ready element stream. Elements arrive in row-major order, so element
// index k = row*NOF_COLS + col. Once both matrices are complete, the pair is
// held stable and offered to a downstream multiplier with mat_valid/mat_ready.
// The multiplier takes the pair when mat_valid && mat_ready. After that the
// loader goes back to loading A, and it overwrites the previous contents one
// element at a time.
//
// Ports
//   clk        : single rising-edge clock
//   reset      : synchronous, active-high; clears state, counters and matrices
//   clear      : synchronous abort; restarts the load at A[0], keeps data and
//                frame count, and discards any element offered in that cycle
//   in_valid   : upstream element valid
//   in_ready   : loader can take an element this cycle (combinational)
//   in_data    : element value
//   matrix_a   : flattened matrix A, element k at [k*DATA_WIDTH +: DATA_WIDTH]
//   matrix_b   : flattened matrix B, same layout
//   mat_valid  : A and B are complete and offered downstream
//   mat_ready  : downstream consumes the offered pair
//   state_o    : current state (LOAD_A=0, LOAD_B=1, PRESENT=2)
//   frame_cnt  : number of matrix pairs handed off (wraps at 16 bits)
// -----------------------------------------------------------------------------
module matrix_input_loader #(
    parameter int NOF_ROWS   = 8,
    parameter int NOF_COLS   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_WIDTH-1:0]                   in_data,
    output logic [NOF_ROWS*NOF_COLS*DATA_WIDTH-1:0] matrix_a,
    output logic [NOF_ROWS*NOF_COLS*DATA_WIDTH-1:0] matrix_b,
    output logic                                    mat_valid,
    input  logic                                    mat_ready,
    output logic [1:0]                              state_o,
    output logic [15:0]                             frame_cnt
);

    localparam int N   = NOF_ROWS * NOF_COLS;
    localparam int K_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(N - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [K_W-1:0]           k_q, k_d;
    logic                     mat_valid_q, mat_valid_d;
    logic [15:0]              frame_cnt_q, frame_cnt_d;
    logic [N*DATA_WIDTH-1:0]  mat_a_q, mat_b_q;

    logic loading;
    logic accept;
    logic last_elem;
    logic handoff;

    // -------------------------------------------------------------------------
    // Handshake qualifiers
    // -------------------------------------------------------------------------
    assign loading   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign accept    = in_valid && in_ready;
    assign last_elem = (k_q == K_LAST);
    // clear wins over a hand-off in the same cycle, so the pair is not counted.
    assign handoff   = (state_q == PRESENT) && mat_valid_q && mat_ready && !clear;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples values from before the edge, whatever the block order.
        if (reset) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: each combinational output gets a default before any branch.
        // Then no path leaves it unassigned, and no latch is inferred.
        state_d = state_q;
        case (state_q)
            LOAD_A:  if (accept && last_elem) state_d = LOAD_B;
            LOAD_B:  if (accept && last_elem) state_d = PRESENT;
            PRESENT: if (mat_ready)           state_d = LOAD_A;
            default:                          state_d = LOAD_A; // encoding 3 recovers
        endcase
        if (clear) begin
            state_d = LOAD_A;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = loading && !clear;
        state_o   = state_q;
        mat_valid = mat_valid_q;
        frame_cnt = frame_cnt_q;
        matrix_a  = mat_a_q;
        matrix_b  = mat_b_q;
    end

    // -------------------------------------------------------------------------
    // Element index, presentation flag and frame counter
    // -------------------------------------------------------------------------
    always_comb begin
        k_d         = k_q;
        frame_cnt_d = frame_cnt_q;
        // Registered copy of "in PRESENT". It rises the cycle after the last
        // element of B is accepted and falls the cycle after the hand-off or
        // clear.
        mat_valid_d = (state_d == PRESENT);

        if (clear || !loading) begin
            k_d = '0;
        end else if (accept) begin
            k_d = last_elem ? '0 : k_q + 1'b1;
        end

        if (handoff) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k_q         <= '0;
            mat_valid_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            k_q         <= k_d;
            mat_valid_q <= mat_valid_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Matrix storage: one write-enabled element slot per accepted transfer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the storage has a reset because after reset both matrices must
        // read as zero. A hand-off or clear does not wipe it. Later loads
        // overwrite it one element at a time.
        if (reset) begin
            mat_a_q <= '0;
            mat_b_q <= '0;
        end else if (accept) begin
            if (state_q == LOAD_A) begin
                mat_a_q[k_q*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end else begin
                mat_b_q[k_q*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_input_loader.sv
// -----------------------------------------------------------------------------
// tb_matrix_input_loader
//
// Self-checking bench for matrix_input_loader (8x8, 8-bit elements).
// A behavioural model keeps each frame as plain arrays plus an accepted-element
// count. A compare process checks every DUT output against the model on each
// falling edge. Directed scenarios pin the model with hand-computed literals.
// -----------------------------------------------------------------------------
module tb_matrix_input_loader;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int DW = 8;
    localparam int N  = R * C;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      in_data;
    logic [N*DW-1:0]    matrix_a;
    logic [N*DW-1:0]    matrix_b;
    logic               mat_valid;
    logic               mat_ready;
    logic [1:0]         state_o;
    logic [15:0]        frame_cnt;

    always #5 clk = ~clk;

    matrix_input_loader #(
        .NOF_ROWS   (R),
        .NOF_COLS   (C),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .mat_valid (mat_valid),
        .mat_ready (mat_ready),
        .state_o   (state_o),
        .frame_cnt (frame_cnt)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model: a frame is 2*N accepted elements. The first N fill A
    // and the next N fill B. After that the pair is presented until it is taken.
    // -------------------------------------------------------------------------
    logic [DW-1:0] m_a [N];
    logic [DW-1:0] m_b [N];
    int            m_cnt;       // elements accepted in the current frame
    bit            m_present;
    logic [15:0]   m_frame;     // hand-offs seen since reset
    logic [15:0]   m_ofs = '0;  // offset applied when the counter is preloaded
    bit            m_live = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                m_a[k] <= '0;
                m_b[k] <= '0;
            end
            m_cnt     <= 0;
            m_present <= 1'b0;
            m_frame   <= '0;
            m_live    <= 1'b1;
        end else if (clear) begin
            m_cnt     <= 0;
            m_present <= 1'b0;
        end else if (m_present) begin
            if (mat_ready) begin
                m_present <= 1'b0;
                m_frame   <= m_frame + 16'd1;
            end
        end else if (in_valid) begin
            if (m_cnt < N) m_a[m_cnt]   <= in_data;
            else           m_b[m_cnt-N] <= in_data;
            if (m_cnt == 2*N-1) begin
                m_cnt     <= 0;
                m_present <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Compare process: every falling edge once the model has seen reset.
    always @(negedge clk) begin
        if (m_live) begin
            logic [N*DW-1:0] ea;
            logic [N*DW-1:0] eb;
            logic [1:0]      es;
            for (int k = 0; k < N; k++) begin
                ea[k*DW +: DW] = m_a[k];
                eb[k*DW +: DW] = m_b[k];
            end
            es = m_present ? 2'd2 : ((m_cnt < N) ? 2'd0 : 2'd1);
            check("in_ready",  {{(N*DW-1){1'b0}}, in_ready},  {{(N*DW-1){1'b0}}, (!m_present && !clear)});
            check("mat_valid", {{(N*DW-1){1'b0}}, mat_valid}, {{(N*DW-1){1'b0}}, m_present});
            check("state_o",   {{(N*DW-2){1'b0}}, state_o},   {{(N*DW-2){1'b0}}, es});
            check("frame_cnt", {{(N*DW-16){1'b0}}, frame_cnt}, {{(N*DW-16){1'b0}}, 16'(m_frame + m_ofs)});
            check("matrix_a",  matrix_a, ea);
            check("matrix_b",  matrix_b, eb);
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the rising edge)
    // -------------------------------------------------------------------------
    task automatic load_frame();
        for (int i = 0; i < 2*N; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        mat_ready = 1'b1;
        @(posedge clk); #1;
        mat_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; mat_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---- stream 0..127 directly after reset ----
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd0;
        @(negedge clk);
        check("in_ready_first_cycle", {{(N*DW-1){1'b0}}, in_ready}, 1);
        check("state_after_reset", {{(N*DW-2){1'b0}}, state_o}, 0);
        for (int i = 0; i < 2*N; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i);
            if (i == 2*N-1) begin
                @(negedge clk);
                check("mat_valid_before_last", {{(N*DW-1){1'b0}}, mat_valid}, 0);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("mat_valid_after_last", {{(N*DW-1){1'b0}}, mat_valid}, 1);
        check("a_first", {{(N*DW-8){1'b0}}, matrix_a[7:0]}, 0);
        check("a_last",  {{(N*DW-8){1'b0}}, matrix_a[511:504]}, 63);
        check("b_first", {{(N*DW-8){1'b0}}, matrix_b[7:0]}, 64);
        check("b_last",  {{(N*DW-8){1'b0}}, matrix_b[511:504]}, 127);

        // ---- back-pressure in PRESENT ----
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(negedge clk);
            check("present_in_ready", {{(N*DW-1){1'b0}}, in_ready}, 0);
            check("present_valid",    {{(N*DW-1){1'b0}}, mat_valid}, 1);
            @(posedge clk); #1;
        end
        handoff();
        in_valid = 1'b0;
        @(negedge clk);
        check("frame_cnt_one", {{(N*DW-16){1'b0}}, frame_cnt}, 1);
        check("state_after_handoff", {{(N*DW-2){1'b0}}, state_o}, 0);
        @(posedge clk); #1;

        // ---- clear at k=30 in LOAD_B with an element offered ----
        for (int i = 0; i < N + 30; i++) begin
            in_valid = 1'b1;
            in_data  = DW'($urandom);
            @(posedge clk); #1;
        end
        clear    = 1'b1;
        in_data  = 8'hA5;
        @(negedge clk);
        check("in_ready_during_clear", {{(N*DW-1){1'b0}}, in_ready}, 0);
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("state_after_clear", {{(N*DW-2){1'b0}}, state_o}, 0);
        @(posedge clk); #1;
        load_frame();
        @(negedge clk);
        check("valid_after_fresh_load", {{(N*DW-1){1'b0}}, mat_valid}, 1);
        @(posedge clk); #1;
        handoff();

        // ---- randomized traffic: 50% valid gaps, random ready, rare clear ----
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(1) == 1);
            in_data   = DW'($urandom);
            mat_ready = ($urandom_range(3) == 0);
            clear     = ($urandom_range(999) == 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; mat_ready = 1'b0;
        clear    = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;

        // ---- reset while presenting with mat_ready high ----
        load_frame();
        reset     = 1'b1;
        mat_ready = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        mat_ready = 1'b0;
        @(negedge clk);
        check("reset_frame_cnt", {{(N*DW-16){1'b0}}, frame_cnt}, 0);
        check("reset_mat_valid", {{(N*DW-1){1'b0}}, mat_valid}, 0);
        check("reset_matrix_a", matrix_a, '0);
        check("reset_matrix_b", matrix_b, '0);
        @(posedge clk); #1;

        // ---- frame counter wrap: preload 0xFFFF, one more hand-off ----
        #2;
        force dut.frame_cnt_q = 16'hFFFF;
        m_ofs = 16'hFFFF - m_frame;
        @(posedge clk); #1;
        release dut.frame_cnt_q;
        load_frame();
        handoff();
        @(negedge clk);
        check("frame_cnt_wrap", {{(N*DW-16){1'b0}}, frame_cnt}, 0);
        check("state_after_wrap", {{(N*DW-2){1'b0}}, state_o}, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
